audio_out_gain: RTL and testbench
=================================

# audio_out_gain

Stereo output gain stage directly upstream of the SGTL5000 DSP-mode serial interface. Accepts one signed stereo sample pair per handshake and applies an independent unsigned Q1.7 gain to each channel using a single shared multiplier. Saturates and left-justifies each channel into a 32-bit slot, then updates the 64-bit parallel frame word atomically. The serial interface latches that word at an arbitrary frame boundary.

## Interface
- IN_BITS, 22, width of the signed input samples; must satisfy IN_BITS < OUT_BITS
- OUT_BITS, 32, slot width per channel; the frame word is 2*OUT_BITS = 64 bits
- GAIN_BITS, 8, unsigned gain width, Q1.7; 0x80 = unity
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample pair presented
- in_ready  out  1  block can accept; reset value 1
- in_left  in  IN_BITS  signed left sample
- in_right  in  IN_BITS  signed right sample
- gain_left  in  GAIN_BITS  left target gain
- gain_right  in  GAIN_BITS  right target gain
- audio_o  out  2*OUT_BITS  frame word, {left slot, right slot}; left slot is transmitted first; reset value 0
- clip  out  1  sticky saturation flag; reset value 0
- clip_clr  in  1  clears clip

## Operation
- FSM states: IDLE, MUL_L, MUL_R, COMMIT. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register in_left, in_right and both gains (the effective gains; see Configuration), then go to MUL_L.
- MUL_L:
  - Register p = in_left × {1'b0, gain_left}.
  - p is a signed product of IN_BITS+GAIN_BITS+1 bits.
  - Go to MUL_R.
- MUL_R:
  - Same operation on the right channel using the shared multiplier.
  - Go to COMMIT.
- COMMIT:
  - Per channel, s = p >>> 7 (arithmetic shift, floor toward −inf).
  - Saturate s to the signed IN_BITS range [−2^(IN_BITS−1), 2^(IN_BITS−1)−1].
  - Slot value = {saturated s, (OUT_BITS−IN_BITS) zeros}.
  - Write both slots of audio_o in the same cycle. audio_o is never observable half-updated.
  - Return to IDLE.
- in_ready=0 in MUL_L, MUL_R and COMMIT. in_valid is ignored in those states, and input values are not held across them.
- clip:
  - Set in COMMIT if either channel saturates.
  - clip_clr=1 clears clip.
  - If clip_clr and a saturation occur in the same cycle, set wins.
- rst takes priority in any state:
  - FSM returns to IDLE.
  - audio_o=0, clip=0.
  - Any in-flight pair is discarded.

## Timing
- Accept edge k (in_valid & in_ready). Product L is registered at k+1, product R at k+2.
- audio_o and clip update at edge k+3. in_ready is high again after k+3.
- Throughput: one pair per 4 cycles.
- Back-to-back: in_valid held high produces accepts at k, k+4, k+8, …
- audio_o holds its value between commits. Frame consumers latch at any cycle and always see a consistent pair.
- rst asserted on edge k+1 or k+2: no commit occurs at k+3; audio_o=0 from the edge rst is sampled.

## Configuration
- AUDIO_OUT_GAIN_RAMP_EN:
  - Defined:
    - Each channel keeps an applied gain register, reset to 0.
    - On each accept, the applied gain steps by ±1 toward its target gain (or stays if equal).
    - The stepped value is the gain used for that pair.
    - Gives soft-start after reset and click-free volume changes.
  - Undefined: no applied gain registers; the target gains are registered directly at accept.

## Test plan
- Macro undefined, gains 0x80, in_left=22'h000001, in_right=22'h3FFFFF → after 3 cycles audio_o={32'h0000_0400, 32'hFFFF_FC00}, clip=0.
- Macro undefined, gain_left=0xC0, in_left=22'h000100; gain_right=0x00, in_right=22'h0ABCDE → left slot 32'h0006_0000, right slot 32'h0000_0000.
- Gains 0xFF, in_left=22'h1FFFFF, in_right=22'h200000 → audio_o={32'h7FFF_FC00, 32'h8000_0000}, clip=1.
  - Next pair in range → clip stays 1.
  - clip_clr pulse → clip=0.
  - clip_clr in the same cycle as a saturating COMMIT → clip=1.
- Floor rounding: gain 0x40, in_left=22'h3FFFFF (−1) → left slot 32'hFFFF_FC00.
- Handshake and reset:
  - in_valid held high for 12 cycles → exactly 3 accepts; in_ready pattern 1,0,0,0 repeating.
  - rst at accept+2 → no commit; audio_o=0, in_ready=1 next cycle.
- Macro defined, reset, gains 0x80, in_left=22'h000080 repeatedly:
  - Pair 1 left slot 32'h0000_0400; pair 128 left slot 32'h0002_0000; constant thereafter.
  - Then drop the target gain to 0x7E → pairs 129 and 130 use gains 0x7F and 0x7E.

Source files
------------

// File: rtl/audio_out_gain_if.sv
// Handshake, sample, gain and frame-word bundle between a sample source and audio_out_gain.
interface audio_out_gain_if #(
    parameter int IN_BITS   = 22,
    parameter int OUT_BITS  = 32,
    parameter int GAIN_BITS = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_BITS-1:0]    in_left;
    logic [IN_BITS-1:0]    in_right;
    logic [GAIN_BITS-1:0]  gain_left;
    logic [GAIN_BITS-1:0]  gain_right;
    logic [2*OUT_BITS-1:0] audio_o;
    logic                  clip;
    logic                  clip_clr;

    modport master (
        output in_valid, in_left, in_right, gain_left, gain_right, clip_clr,
        input  in_ready, audio_o, clip
    );

    modport slave (
        input  in_valid, in_left, in_right, gain_left, gain_right, clip_clr,
        output in_ready, audio_o, clip
    );
endinterface

// File: rtl/audio_out_gain.sv
// Stereo Q1.7 gain stage with one shared multiplier, saturation and atomic 64-bit frame update.
// Optional soft gain ramp: define AUDIO_OUT_GAIN_RAMP_EN.
module audio_out_gain #(
    parameter int IN_BITS   = 22,
    parameter int OUT_BITS  = 32,
    parameter int GAIN_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    audio_out_gain_if.slave bus
);
    localparam int PROD_BITS = IN_BITS + GAIN_BITS + 1;
    localparam int FRAC_BITS = GAIN_BITS - 1;
    localparam int PAD_BITS  = OUT_BITS - IN_BITS;
    localparam int TOP_BITS  = PROD_BITS - IN_BITS + 1;

    typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, COMMIT} state_t;

    typedef struct packed {
        logic               sat;
        logic [IN_BITS-1:0] val;
    } sat_t;

    state_t                       state_q;
    logic                         in_ready_q;
    logic [IN_BITS-1:0]           left_q;
    logic [IN_BITS-1:0]           right_q;
    logic [GAIN_BITS-1:0]         gain_l_q;
    logic [GAIN_BITS-1:0]         gain_r_q;
    logic signed [PROD_BITS-1:0]  prod_l_q;
    logic signed [PROD_BITS-1:0]  prod_r_q;
    logic [2*OUT_BITS-1:0]        audio_q;
    logic                         clip_q;

    logic [GAIN_BITS-1:0]         gain_l_d;
    logic [GAIN_BITS-1:0]         gain_r_d;
    logic [IN_BITS-1:0]           mul_a;
    logic [GAIN_BITS-1:0]         mul_g;
    logic signed [PROD_BITS-1:0]  prod_d;
    sat_t                         sat_l;
    sat_t                         sat_r;
    logic [2*OUT_BITS-1:0]        audio_d;
    logic                         clip_d;

    // Drop the Q1.7 fraction (floor) and clamp into the signed IN_BITS range.
    function automatic sat_t saturate(input logic signed [PROD_BITS-1:0] p);
        logic signed [PROD_BITS-1:0] s;
        logic [TOP_BITS-1:0]         top;
        sat_t                        r;
        s     = p >>> FRAC_BITS;
        top   = s[PROD_BITS-1:IN_BITS-1];
        r.sat = !((&top) || !(|top));
        if (!r.sat)
            r.val = s[IN_BITS-1:0];
        else if (s[PROD_BITS-1])
            r.val = {1'b1, {(IN_BITS-1){1'b0}}};
        else
            r.val = {1'b0, {(IN_BITS-1){1'b1}}};
        return r;
    endfunction

`ifdef AUDIO_OUT_GAIN_RAMP_EN
    function automatic logic [GAIN_BITS-1:0] ramp_step(
        input logic [GAIN_BITS-1:0] applied,
        input logic [GAIN_BITS-1:0] target
    );
        if (applied < target)
            return applied + GAIN_BITS'(1);
        else if (applied > target)
            return applied - GAIN_BITS'(1);
        else
            return applied;
    endfunction
`endif

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
`ifdef AUDIO_OUT_GAIN_RAMP_EN
        // gain_*_q doubles as the applied gain; it moves one LSB per accepted pair.
        gain_l_d = ramp_step(gain_l_q, bus.gain_left);
        gain_r_d = ramp_step(gain_r_q, bus.gain_right);
`else
        gain_l_d = bus.gain_left;
        gain_r_d = bus.gain_right;
`endif
        mul_a   = (state_q == MUL_L) ? left_q   : right_q;
        mul_g   = (state_q == MUL_L) ? gain_l_q : gain_r_q;
        prod_d  = {{(GAIN_BITS+1){mul_a[IN_BITS-1]}}, mul_a} * {{IN_BITS{1'b0}}, mul_g};
        sat_l   = saturate(prod_l_q);
        sat_r   = saturate(prod_r_q);
        audio_d = {sat_l.val, {PAD_BITS{1'b0}}, sat_r.val, {PAD_BITS{1'b0}}};
        clip_d  = clip_q;
        if (state_q == COMMIT && (sat_l.sat || sat_r.sat))
            clip_d = 1'b1;
        else if (bus.clip_clr)
            clip_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            left_q     <= '0;
            right_q    <= '0;
            gain_l_q   <= '0;
            gain_r_q   <= '0;
            prod_l_q   <= '0;
            prod_r_q   <= '0;
            audio_q    <= '0;
            clip_q     <= 1'b0;
        end else begin
            clip_q <= clip_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        left_q     <= bus.in_left;
                        right_q    <= bus.in_right;
                        gain_l_q   <= gain_l_d;
                        gain_r_q   <= gain_r_d;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL_L;
                    end
                end
                MUL_L: begin
                    prod_l_q <= prod_d;
                    state_q  <= MUL_R;
                end
                MUL_R: begin
                    prod_r_q <= prod_d;
                    state_q  <= COMMIT;
                end
                COMMIT: begin
                    // Both slots land on the same edge so a frame consumer never sees a torn pair.
                    audio_q    <= audio_d;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.audio_o  = audio_q;
    assign bus.clip     = clip_q;
endmodule

// File: tb/tb_audio_out_gain.sv
// Scoreboard bench for audio_out_gain; define AUDIO_OUT_GAIN_RAMP_EN to exercise the gain ramp.
module tb_audio_out_gain;
    localparam int IN_BITS   = 22;
    localparam int OUT_BITS  = 32;
    localparam int GAIN_BITS = 8;
    localparam longint MAXV  = (longint'(1) << (IN_BITS - 1)) - 1;
    localparam longint MINV  = -(longint'(1) << (IN_BITS - 1));

    typedef struct packed {
        logic                sat;
        logic [OUT_BITS-1:0] slot;
    } mres_t;

    typedef struct packed {
        logic [2*OUT_BITS-1:0] audio;
        logic                  clip;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];
    logic [2*OUT_BITS-1:0] last_audio = '0;
    logic clip_model = 1'b0;

    always #5 clk = ~clk;

    audio_out_gain_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .GAIN_BITS(GAIN_BITS)) bus ();

    audio_out_gain #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .GAIN_BITS(GAIN_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: exact integer product, floor divide by 128, clamp, left-justify.
    function automatic mres_t model(input logic [IN_BITS-1:0] x, input logic [GAIN_BITS-1:0] g);
        longint p;
        longint s;
        mres_t  r;
        p     = longint'($signed(x)) * longint'(g);
        s     = p >>> 7;
        r.sat = 1'b0;
        if (s > MAXV) begin
            s     = MAXV;
            r.sat = 1'b1;
        end else if (s < MINV) begin
            s     = MINV;
            r.sat = 1'b1;
        end
        r.slot = {s[IN_BITS-1:0], {(OUT_BITS-IN_BITS){1'b0}}};
        return r;
    endfunction

    task automatic do_pair(
        input logic [IN_BITS-1:0]    l,
        input logic [IN_BITS-1:0]    r,
        input logic [GAIN_BITS-1:0]  gl,
        input logic [GAIN_BITS-1:0]  gr,
        input logic                  clr_at_commit,
        input logic [2*OUT_BITS-1:0] exp_audio,
        input logic                  exp_clip,
        input string                 name
    );
        exp_t e;
        int   waited;
        e.audio = exp_audio;
        e.clip  = exp_clip;
        sb.push_back(e);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            $display("FAIL %s ready_timeout in_ready=%b required 1", name, bus.in_ready);
            void'(sb.pop_back());
            return;
        end
        bus.in_valid   = 1'b1;
        bus.in_left    = l;
        bus.in_right   = r;
        bus.gain_left  = gl;
        bus.gain_right = gr;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_left    = IN_BITS'($urandom);
        bus.in_right   = IN_BITS'($urandom);
        bus.gain_left  = GAIN_BITS'($urandom);
        bus.gain_right = GAIN_BITS'($urandom);
        total++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL %s busy in_ready=%b required 0", name, bus.in_ready);
        else
            passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.audio_o !== last_audio)
            $display("FAIL %s hold audio_o=%h required %h", name, bus.audio_o, last_audio);
        else
            passed++;
        bus.clip_clr = clr_at_commit;
        @(negedge clk);
        bus.clip_clr = 1'b0;
        e = sb.pop_front();
        total++;
        if (bus.audio_o !== e.audio)
            $display("FAIL %s audio_o=%h required %h", name, bus.audio_o, e.audio);
        else
            passed++;
        total++;
        if (bus.clip !== e.clip)
            $display("FAIL %s clip=%b required %b", name, bus.clip, e.clip);
        else
            passed++;
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL %s ready_after in_ready=%b required 1", name, bus.in_ready);
        else
            passed++;
        last_audio = e.audio;
        clip_model = e.clip;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_ready in_ready=%b required 1", bus.in_ready);
        else passed++;
        total++;
        if (bus.audio_o !== '0) $display("FAIL reset_audio audio_o=%h required 0", bus.audio_o);
        else passed++;
        total++;
        if (bus.clip !== 1'b0) $display("FAIL reset_clip clip=%b required 0", bus.clip);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_reset_ready in_ready=%b required 1", bus.in_ready);
        else passed++;
        last_audio = '0;
        clip_model = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bus.in_valid   = 1'b1;
        bus.in_left    = 22'h001000;
        bus.in_right   = 22'h001000;
        bus.gain_left  = 8'h80;
        bus.gain_right = 8'h80;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.audio_o !== '0) $display("FAIL midreset_audio audio_o=%h required 0", bus.audio_o);
        else passed++;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL midreset_ready in_ready=%b required 1", bus.in_ready);
        else passed++;
        total++;
        if (bus.clip !== 1'b0) $display("FAIL midreset_clip clip=%b required 0", bus.clip);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.audio_o !== '0) $display("FAIL midreset_no_commit audio_o=%h required 0", bus.audio_o);
        else passed++;
        last_audio = '0;
        clip_model = 1'b0;
    endtask

`ifdef AUDIO_OUT_GAIN_RAMP_EN
    task automatic test_ramp();
        logic [GAIN_BITS-1:0]  g_l;
        logic [GAIN_BITS-1:0]  g_r;
        logic [GAIN_BITS-1:0]  tgt;
        logic [2*OUT_BITS-1:0] exp_audio;
        mres_t ml;
        mres_t mr;
        g_l = '0;
        g_r = '0;
        for (int n = 1; n <= 130; n++) begin
            tgt = (n <= 128) ? 8'h80 : 8'h7E;
            if (g_l < tgt) g_l = g_l + 8'd1; else if (g_l > tgt) g_l = g_l - 8'd1;
            if (g_r < 8'h80) g_r = g_r + 8'd1;
            ml = model(22'h000080, g_l);
            mr = model(22'h000080, g_r);
            exp_audio = {ml.slot, mr.slot};
            if (n == 1)   exp_audio[63:32] = 32'h0000_0400;
            if (n >= 128 && n <= 128) exp_audio[63:32] = 32'h0002_0000;
            if (n == 129) exp_audio[63:32] = 32'h0001_FC00;
            if (n == 130) exp_audio[63:32] = 32'h0001_F800;
            do_pair(22'h000080, 22'h000080, tgt, 8'h80, 1'b0, exp_audio, 1'b0, $sformatf("ramp%0d", n));
        end
    endtask
`else
    task automatic test_unity();
        do_pair(22'h000001, 22'h3FFFFF, 8'h80, 8'h80, 1'b0,
                {32'h0000_0400, 32'hFFFF_FC00}, 1'b0, "unity");
    endtask

    task automatic test_gain_mix();
        do_pair(22'h000100, 22'h0ABCDE, 8'hC0, 8'h00, 1'b0,
                {32'h0006_0000, 32'h0000_0000}, 1'b0, "gain_mix");
    endtask

    task automatic test_floor();
        do_pair(22'h3FFFFF, 22'h000003, 8'h40, 8'h40, 1'b0,
                {32'hFFFF_FC00, 32'h0000_0400}, 1'b0, "floor");
    endtask

    task automatic test_back_to_back();
        logic [11:0] ready_seq;
        int          accepts;
        accepts        = 0;
        ready_seq      = '0;
        bus.in_valid   = 1'b1;
        bus.in_left    = 22'h000010;
        bus.in_right   = 22'h000010;
        bus.gain_left  = 8'h80;
        bus.gain_right = 8'h80;
        for (int i = 0; i < 12; i++) begin
            ready_seq[i] = bus.in_ready;
            if (bus.in_ready === 1'b1) accepts++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (accepts != 3) $display("FAIL b2b_accepts count=%0d required 3", accepts);
        else passed++;
        total++;
        if (ready_seq !== 12'h111) $display("FAIL b2b_ready_pattern seq=%b required %b", ready_seq, 12'h111);
        else passed++;
        total++;
        if (bus.audio_o !== {32'h0000_4000, 32'h0000_4000})
            $display("FAIL b2b_audio audio_o=%h required %h", bus.audio_o, {32'h0000_4000, 32'h0000_4000});
        else passed++;
        total++;
        if (bus.clip !== 1'b0) $display("FAIL b2b_clip clip=%b required 0", bus.clip);
        else passed++;
        last_audio = {32'h0000_4000, 32'h0000_4000};
    endtask

    task automatic test_random();
        logic [IN_BITS-1:0]   l;
        logic [IN_BITS-1:0]   r;
        logic [GAIN_BITS-1:0] gl;
        logic [GAIN_BITS-1:0] gr;
        mres_t ml;
        mres_t mr;
        for (int n = 0; n < 10; n++) begin
            l  = IN_BITS'($urandom);
            r  = IN_BITS'($urandom);
            gl = GAIN_BITS'($urandom);
            gr = GAIN_BITS'($urandom);
            ml = model(l, gl);
            mr = model(r, gr);
            do_pair(l, r, gl, gr, 1'b0, {ml.slot, mr.slot}, clip_model | ml.sat | mr.sat,
                    $sformatf("random%0d", n));
        end
    endtask

    task automatic test_saturation();
        do_pair(22'h1FFFFF, 22'h200000, 8'hFF, 8'hFF, 1'b0,
                {32'h7FFF_FC00, 32'h8000_0000}, 1'b1, "sat");
        do_pair(22'h000001, 22'h000002, 8'h80, 8'h80, 1'b0,
                {32'h0000_0400, 32'h0000_0800}, 1'b1, "sat_sticky");
        bus.clip_clr = 1'b1;
        @(negedge clk);
        bus.clip_clr = 1'b0;
        total++;
        if (bus.clip !== 1'b0) $display("FAIL clip_clr clip=%b required 0", bus.clip);
        else passed++;
        do_pair(22'h1FFFFF, 22'h000002, 8'hFF, 8'hFF, 1'b1,
                {32'h7FFF_FC00, 32'h0000_0C00}, 1'b1, "sat_wins_clr");
    endtask
`endif

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_left    = '0;
        bus.in_right   = '0;
        bus.gain_left  = '0;
        bus.gain_right = '0;
        bus.clip_clr   = 1'b0;
        test_reset();
`ifdef AUDIO_OUT_GAIN_RAMP_EN
        test_ramp();
`else
        test_unity();
        test_gain_mix();
        test_floor();
        test_back_to_back();
        test_random();
        test_saturation();
`endif
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
